// File: rtl/insn_prefetch_queue_if.sv
// Fetch-side bundle of the prefetch queue: the instruction-memory read port,
// the decoder valid/stall handshake and the redirect request.
interface insn_prefetch_queue_if #(
  parameter int LEN_INSN      = 32,
  parameter int MEM_INSN_ADDR = 10
);
  logic                     flush_i;
  logic [MEM_INSN_ADDR-1:0] flush_addr_i;
  logic                     imem_req_o;
  logic [MEM_INSN_ADDR-1:0] imem_addr_o;
  logic [LEN_INSN-1:0]      imem_data_i;
  logic                     valid_o;
  logic                     stall_i;
  logic [LEN_INSN-1:0]      insn_o;
  logic [MEM_INSN_ADDR-1:0] addr_o;

  modport master (
    input  flush_i, flush_addr_i, imem_data_i, stall_i,
    output imem_req_o, imem_addr_o, valid_o, insn_o, addr_o
  );

  modport slave (
    output flush_i, flush_addr_i, imem_data_i, stall_i,
    input  imem_req_o, imem_addr_o, valid_o, insn_o, addr_o
  );
endinterface

// File: rtl/insn_prefetch_queue.sv
// Sequential instruction prefetcher: one read per cycle into a fixed-latency
// memory, results queued with their addresses and handed to the decoder.
module insn_prefetch_queue #(
  parameter int LEN_INSN      = 32,
  parameter int MEM_INSN_ADDR = 10,
  parameter int DEPTH         = 4
) (
  input  logic                clk,
  input  logic                rst,
  insn_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [MEM_INSN_ADDR-1:0] pc_reg;
  logic [CW-1:0]            count_reg;
  logic [PW-1:0]            head_reg;
  logic [PW-1:0]            tail_reg;
  logic                     inflight_reg;
  logic [MEM_INSN_ADDR-1:0] inflight_addr_reg;

  logic [LEN_INSN-1:0]      insn_mem [DEPTH];
  logic [MEM_INSN_ADDR-1:0] addr_mem [DEPTH];

  logic issue;
  logic push;
  logic pop;

  // Credit counts queued entries plus the read in flight; a pop in the same
  // cycle is deliberately not credited so the request path stays short.
  assign issue = !rst &&
                 (({1'b0, count_reg} + (CW+1)'(inflight_reg)) < (CW+1)'(DEPTH));
  assign push  = inflight_reg && !bus.flush_i;
  assign pop   = bus.valid_o && !bus.stall_i;

  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = pc_reg;
  assign bus.valid_o     = (count_reg != '0) && !bus.flush_i;
  assign bus.insn_o      = insn_mem[head_reg];
  assign bus.addr_o      = addr_mem[head_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && tail_reg == PW'(gi)) begin
          insn_mem[gi] <= bus.imem_data_i;
          addr_mem[gi] <= inflight_addr_reg;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg            <= '0;
      count_reg         <= '0;
      head_reg          <= '0;
      tail_reg          <= '0;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
    end else if (bus.flush_i) begin
      // The request issued this cycle still reaches memory; clearing
      // inflight_reg makes its returning word be ignored.
      pc_reg       <= bus.flush_addr_i;
      count_reg    <= '0;
      head_reg     <= tail_reg;
      inflight_reg <= 1'b0;
    end else begin
      if (issue) begin
        pc_reg            <= pc_reg + MEM_INSN_ADDR'(1);
        inflight_reg      <= 1'b1;
        inflight_addr_reg <= pc_reg;
      end else begin
        inflight_reg <= 1'b0;
      end
      if (push) tail_reg <= tail_reg + PW'(1);
      if (pop)  head_reg <= head_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && count_reg == CW'(DEPTH)));
    end
  end
endmodule

// File: tb/tb_insn_prefetch_queue.sv
// Directed cycle-by-cycle check of the prefetch queue against a hand-built
// timeline: streaming, stall/backpressure, redirects, address wrap, reset.
module tb_insn_prefetch_queue;
  localparam int LI = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  int   row     = 0;

  insn_prefetch_queue_if #(.LEN_INSN(LI), .MEM_INSN_ADDR(AW)) bus ();

  insn_prefetch_queue #(.LEN_INSN(LI), .MEM_INSN_ADDR(AW), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory returns addr + 0x1000 one cycle after a request; a junk word otherwise.
  always_ff @(posedge clk) begin
    if (bus.imem_req_o) bus.imem_data_i <= 32'h1000 + 32'(bus.imem_addr_o);
    else                bus.imem_data_i <= 32'hDEAD_BEEF;
  end

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic [AW-1:0] fa, input logic ereq,
                      input logic [AW-1:0] eia, input logic chkv,
                      input logic ev, input logic [AW-1:0] ea);
    logic [LI-1:0] ei;
    ei = 32'h1000 + 32'(ea);
    rst              = r;
    bus.stall_i      = st;
    bus.flush_i      = fl;
    bus.flush_addr_i = fa;
    #1;
    n_total++;
    assert (bus.imem_req_o === ereq) else begin
      n_bad++;
      $error("FAIL req row=%0d got=%b exp=%b", row, bus.imem_req_o, ereq);
    end
    if (ereq) begin
      n_total++;
      assert (bus.imem_addr_o === eia) else begin
        n_bad++;
        $error("FAIL imem_addr row=%0d got=%h exp=%h", row, bus.imem_addr_o, eia);
      end
    end
    if (chkv) begin
      n_total++;
      assert (bus.valid_o === ev) else begin
        n_bad++;
        $error("FAIL valid row=%0d got=%b exp=%b", row, bus.valid_o, ev);
      end
      if (ev) begin
        n_total++;
        assert (bus.addr_o === ea) else begin
          n_bad++;
          $error("FAIL addr row=%0d got=%h exp=%h", row, bus.addr_o, ea);
        end
        n_total++;
        assert (bus.insn_o === ei) else begin
          n_bad++;
          $error("FAIL insn row=%0d got=%h exp=%h", row, bus.insn_o, ei);
        end
      end
    end
    $display("row %0d rst=%b stall=%b flush=%b req=%b ia=%h valid=%b addr=%h insn=%h",
             row, r, st, fl, bus.imem_req_o, bus.imem_addr_o, bus.valid_o,
             bus.addr_o, bus.insn_o);
    row++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b1;
    bus.stall_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.flush_addr_i = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    // Held in reset: no request, nothing valid, fetch address 0.
    n_total++;
    assert (bus.imem_req_o === 1'b0) else begin
      n_bad++;
      $error("FAIL reset_req got=%b exp=0", bus.imem_req_o);
    end
    n_total++;
    assert (bus.valid_o === 1'b0) else begin
      n_bad++;
      $error("FAIL reset_valid got=%b exp=0", bus.valid_o);
    end
    n_total++;
    assert (bus.imem_addr_o === 10'h000) else begin
      n_bad++;
      $error("FAIL reset_iaddr got=%h exp=000", bus.imem_addr_o);
    end

    //   rst   stall fl    faddr    req   iaddr    chkv  v     addr
    // streaming from 0, count 1 with push+pop every cycle
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h001, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h002, 1'b1, 1'b1, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h003, 1'b1, 1'b1, 10'h001);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h004, 1'b1, 1'b1, 10'h002);
    // short stall to count 3, then push+pop at count 3
    step(1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h005, 1'b1, 1'b1, 10'h003);
    step(1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h006, 1'b1, 1'b1, 10'h003);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h007, 1'b1, 1'b1, 10'h003);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h007, 1'b1, 1'b1, 10'h004);
    // stall until full, hold, then release
    step(1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h008, 1'b1, 1'b1, 10'h005);
    step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h009, 1'b1, 1'b1, 10'h005);
    step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h009, 1'b1, 1'b1, 10'h005);
    step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h009, 1'b1, 1'b1, 10'h005);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h009, 1'b1, 1'b1, 10'h005);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h009, 1'b1, 1'b1, 10'h006);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h00A, 1'b1, 1'b1, 10'h007);
    step(1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h00B, 1'b1, 1'b1, 10'h008);
    step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h00C, 1'b1, 1'b1, 10'h008);
    // flush to 0x20 with the queue full
    step(1'b0, 1'b1, 1'b1, 10'h020, 1'b0, 10'h00C, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h020, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h021, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h022, 1'b1, 1'b1, 10'h020);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h023, 1'b1, 1'b1, 10'h021);
    // flush to 0x3FE with a read in flight and one issued in the flush cycle
    step(1'b0, 1'b0, 1'b1, 10'h3FE, 1'b1, 10'h024, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h3FE, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h3FF, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 1'b1, 1'b1, 10'h3FE);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h001, 1'b1, 1'b1, 10'h3FF);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h002, 1'b1, 1'b1, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h003, 1'b1, 1'b1, 10'h001);
    // one-cycle reset mid-stream with a read in flight
    step(1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h004, 1'b0, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h001, 1'b1, 1'b0, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h002, 1'b1, 1'b1, 10'h000);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h003, 1'b1, 1'b1, 10'h001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
